// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
//   Groups the two byte streams around the UART receive controller:
//     receiver side : rx_en, rx_byte_valid, rx_byte, rx_frame_err
//     consumer side : out_valid, out_data, out_ready
//   modport slave  : the controller (consumes receiver strobes, sources the FIFO head)
//   modport master : the environment (UART receiver model + byte consumer)
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_en;
    logic                  rx_byte_valid;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_frame_err;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport slave (
        output rx_en,
        input  rx_byte_valid,
        input  rx_byte,
        input  rx_frame_err,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        input  rx_en,
        output rx_byte_valid,
        output rx_byte,
        output rx_frame_err,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//   Sits between a UART receiver and a byte consumer. Gates the receiver,
//   buffers good bytes in a first-word-fall-through FIFO, drops framing-error
//   bytes, keeps sticky overrun/framing-error flags and pulses pkt_end after an
//   idle gap of IDLE_CHARS character times following at least one byte.
//
//   clk           clock, rising edge
//   rst           asynchronous reset, active-low
//   en_i          software enable
//   err_clr_i     clears overrun_o and frame_err_o (a same-cycle set wins)
//   fifo_count_o  number of bytes held (0..FIFO_DEPTH)
//   pkt_end_o     1-cycle pulse when the idle gap expires
//   overrun_o     sticky: byte lost because the FIFO was full
//   frame_err_o   sticky: framing-error byte discarded
//   bus           receiver strobes in, FIFO head (valid/ready) out
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200,
    parameter int IDLE_CHARS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_i,
    input  logic                        err_clr_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        pkt_end_o,
    output logic                        overrun_o,
    output logic                        frame_err_o,
    uart_rx_ctrl_if.slave               bus
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int CLK_DIVIDE = CLK_FREQ / BAUD_RATE;
    localparam int TMO        = IDLE_CHARS * 10 * CLK_DIVIDE;
    localparam int IDLE_W     = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_en_q, rx_en_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                  armed_q, armed_d;
    logic                  pkt_end_q, pkt_end_d;

    logic in_run, in_flush, strobe, push_req, err_byte;
    logic full, pop, do_write, drop;

    // Receiver strobes only count while running; OFF and FLUSH ignore them.
    assign in_run   = (state_q == ST_RUN);
    assign in_flush = (state_q == ST_FLUSH);
    assign strobe   = in_run && bus.rx_byte_valid;
    assign push_req = strobe && !bus.rx_frame_err;
    assign err_byte = strobe && bus.rx_frame_err;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop      = (count_q != '0) && bus.out_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_write = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // ------------------------------------------------------------------ FSM
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:   if (en_i)  state_d = ST_RUN;
            ST_RUN:   if (!en_i) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_OFF;
            default:  state_d = ST_OFF;
        endcase
    end

    // rx_en is a register that tracks the state register exactly.
    assign rx_en_d = (state_d == ST_RUN);

    // ------------------------------------------------------------ datapath
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = (overrun_q && !err_clr_i) || drop;
        frame_err_d = (frame_err_q && !err_clr_i) || err_byte;
        idle_cnt_d  = idle_cnt_q;
        armed_d     = armed_q;
        pkt_end_d   = 1'b0;

        if (in_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            idle_cnt_d = '0;
            armed_d    = 1'b0;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_write, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            // Any strobe, good or bad, restarts the gap; it beats the terminal cycle.
            if (strobe) begin
                idle_cnt_d = '0;
                armed_d    = 1'b1;
            end else if (in_run && armed_q) begin
                if (idle_cnt_q == IDLE_W'(TMO - 1)) begin
                    idle_cnt_d = '0;
                    armed_d    = 1'b0;
                    pkt_end_d  = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_OFF;
            rx_en_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            idle_cnt_q  <= '0;
            armed_q     <= 1'b0;
            pkt_end_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_en_q     <= rx_en_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            idle_cnt_q  <= idle_cnt_d;
            armed_q     <= armed_d;
            pkt_end_q   <= pkt_end_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q alone says which
    // entries are meaningful, and leaving it out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= bus.rx_byte;
    end

    // --------------------------------------------------------------- outputs
    assign bus.rx_en     = rx_en_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign fifo_count_o  = count_q;
    assign pkt_end_o     = pkt_end_q;
    assign overrun_o     = overrun_q;
    assign frame_err_o   = frame_err_q;

endmodule
